// File: rtl/vcode_check.sv
// vcode_check: receive-side verification-code checker.
// Recomputes the frame CRC beat by beat (MSB first), strips the expected
// frame ID from the received CRC field and issues a per-frame verdict with
// the frame, delayed by one cycle, CRC field zeroed on the last beat.
// Optional feature macro: VCODE_CHECK_ERR_CNT_EN adds a saturating error
// counter (err_cnt) with a synchronous clear (err_cnt_clr).
//
// Handshake: in_valid qualifies a beat for exactly one cycle; there is no
// ready, every valid beat is consumed. out_valid likewise marks a beat the
// downstream logic must take in that cycle (no backpressure).
module vcode_check #(
  parameter int                   FRAME_WIDTH    = 256,
  parameter int                   DWIDTH         = 64,
  parameter int                   CRC_WIDTH      = 12,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
  parameter int                   FRAME_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [DWIDTH-1:0]         data_in,
  output logic                      out_valid,
  output logic                      out_sof,
  output logic                      out_eof,
  output logic [DWIDTH-1:0]         data_out,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic                      frame_abort,
  output logic                      frame_is_data,
  output logic [FRAME_ID_WIDTH-1:0] exp_frame_id
`ifdef VCODE_CHECK_ERR_CNT_EN
  ,
  input  logic                      err_cnt_clr,
  output logic [15:0]               err_cnt
`endif
);

  localparam int BEATS = FRAME_WIDTH / DWIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_BUSY} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0]      crc_q, crc_d;
  logic                      is_data_q, is_data_d;
  logic [FRAME_ID_WIDTH-1:0] exp_id_q, exp_id_d;

  logic                      out_valid_q, out_valid_d;
  logic                      out_sof_q, out_sof_d;
  logic                      out_eof_q, out_eof_d;
  logic [DWIDTH-1:0]         data_out_q, data_out_d;
  logic                      frame_ok_q, frame_ok_d;
  logic                      frame_err_q, frame_err_d;
  logic                      frame_abort_q, frame_abort_d;
  logic                      frame_is_data_q, frame_is_data_d;

  logic                      accept;
  logic                      last;
  logic [CNT_W-1:0]          cnt_eff;
  logic                      is_data_eff;
  logic [DWIDTH-1:0]         beat_masked;
  logic [CRC_WIDTH-1:0]      crc_new;
  logic [CRC_WIDTH-1:0]      rx_code;
  logic                      match;

  // Bit-serial CRC update over one beat, MSB first.
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c,
                                                    input logic [DWIDTH-1:0]    d);
    logic [CRC_WIDTH-1:0] r;
    logic                 fb;
    r = c;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      fb = r[CRC_WIDTH-1] ^ d[i];
      r  = {r[CRC_WIDTH-2:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  // Beat acceptance, CRC/ID check and next-state/output computation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    crc_d           = crc_q;
    is_data_d       = is_data_q;
    exp_id_d        = exp_id_q;
    out_valid_d     = 1'b0;
    out_sof_d       = 1'b0;
    out_eof_d       = 1'b0;
    data_out_d      = '0;
    frame_ok_d      = 1'b0;
    frame_err_d     = 1'b0;
    frame_abort_d   = 1'b0;
    frame_is_data_d = 1'b0;

    // A sof always restarts the frame, even mid-frame; non-sof beats in IDLE are dropped.
    accept      = in_valid && (in_sof || (state_q == ST_BUSY));
    cnt_eff     = in_sof ? '0 : cnt_q;
    last        = accept && (cnt_eff == CNT_W'(BEATS - 1));
    is_data_eff = in_sof ? (data_in[DWIDTH-1 -: 2] == 2'b01) : is_data_q;

    beat_masked = data_in;
    if (last) beat_masked[CRC_WIDTH-1:0] = '0;

    crc_new = crc_step(in_sof ? '0 : crc_q, beat_masked);
    rx_code = data_in[CRC_WIDTH-1:0] ^ CRC_WIDTH'(exp_id_q);
    match   = (rx_code == crc_new);

    if (accept) begin
      state_d         = last ? ST_IDLE : ST_BUSY;
      cnt_d           = last ? '0 : cnt_eff + CNT_W'(1);
      crc_d           = last ? '0 : crc_new;
      is_data_d       = is_data_eff;
      out_valid_d     = 1'b1;
      out_sof_d       = in_sof;
      out_eof_d       = last;
      data_out_d      = beat_masked;
      frame_ok_d      = last && match;
      frame_err_d     = last && !match;
      frame_abort_d   = in_sof && (state_q == ST_BUSY);
      frame_is_data_d = last && is_data_eff;
      if (last && match && is_data_eff) exp_id_d = exp_id_q + FRAME_ID_WIDTH'(1);
    end
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      crc_q           <= '0;
      is_data_q       <= 1'b0;
      exp_id_q        <= '0;
      out_valid_q     <= 1'b0;
      out_sof_q       <= 1'b0;
      out_eof_q       <= 1'b0;
      data_out_q      <= '0;
      frame_ok_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_abort_q   <= 1'b0;
      frame_is_data_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      crc_q           <= crc_d;
      is_data_q       <= is_data_d;
      exp_id_q        <= exp_id_d;
      out_valid_q     <= out_valid_d;
      out_sof_q       <= out_sof_d;
      out_eof_q       <= out_eof_d;
      data_out_q      <= data_out_d;
      frame_ok_q      <= frame_ok_d;
      frame_err_q     <= frame_err_d;
      frame_abort_q   <= frame_abort_d;
      frame_is_data_q <= frame_is_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_sof       = out_sof_q;
  assign out_eof       = out_eof_q;
  assign data_out      = data_out_q;
  assign frame_ok      = frame_ok_q;
  assign frame_err     = frame_err_q;
  assign frame_abort   = frame_abort_q;
  assign frame_is_data = frame_is_data_q;
  assign exp_frame_id  = exp_id_q;

`ifdef VCODE_CHECK_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of error and abort pulses; clear wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) err_cnt_d = '0;
    else if ((frame_err_q || frame_abort_q) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_vcode_check.sv
// tb_vcode_check: directed bench for vcode_check with a whole-frame CRC
// model of the TX verification-code generator.
module tb_vcode_check;

  localparam int FW = 256;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          out_valid, out_sof, out_eof;
  logic [DW-1:0] data_out;
  logic          frame_ok, frame_err, frame_abort, frame_is_data;
  logic [7:0]    exp_frame_id;
`ifdef VCODE_CHECK_ERR_CNT_EN
  logic          err_cnt_clr = 1'b0;
  logic [15:0]   err_cnt;
`endif

  int         errors = 0;
  int         checks = 0;
  int         ok_seen = 0;
  logic [7:0] tb_id = 8'd0;

  vcode_check dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .data_in       (data_in),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .data_out      (data_out),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .frame_abort   (frame_abort),
    .frame_is_data (frame_is_data),
    .exp_frame_id  (exp_frame_id)
`ifdef VCODE_CHECK_ERR_CNT_EN
    ,
    .err_cnt_clr   (err_cnt_clr),
    .err_cnt       (err_cnt)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  // Whole-frame serial CRC, MSB first, over a frame whose CRC field is zero.
  function automatic logic [11:0] model_crc(input logic [FW-1:0] f);
    logic [11:0] r;
    logic        fb;
    r = '0;
    for (int i = FW - 1; i >= 0; i--) begin
      fb = r[11] ^ f[i];
      r  = {r[10:0], 1'b0};
      if (fb) r = r ^ 12'h02f;
    end
    return r;
  endfunction

  // TX generator model: random payload, header, CRC field = crc ^ id.
  task automatic make_frame(input logic [7:0] id, input logic [1:0] hdr,
                            output logic [FW-1:0] f);
    f = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    f[FW-1 -: 2] = hdr;
    f[11:0]      = '0;
    f[11:0]      = model_crc(f) ^ {4'b0, id};
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
`ifdef VCODE_CHECK_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tb_id = 8'd0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input bit sof);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0 || frame_abort !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got valid=%b ok=%b err=%b abort=%b, expected all 0",
               out_valid, frame_ok, frame_err, frame_abort);
    end
  endtask

  // Sends the first n beats of a frame and checks they pass through verdict-free.
  task automatic send_partial(input logic [FW-1:0] f, input int n);
    logic [DW-1:0] beat;
    for (int b = 0; b < n; b++) begin
      beat = f[FW-1-DW*b -: DW];
      drive_beat(beat, b == 0);
      checks++;
      if (out_valid !== 1'b1 || data_out !== beat || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL partial_beat%0d: got valid=%b data=%h ok=%b err=%b, expected 1 %h 0 0",
                 b, out_valid, data_out, frame_ok, frame_err, beat);
      end
    end
  endtask

  // Sends a full frame and checks every output beat and the verdict.
  task automatic send_frame(input logic [FW-1:0] f, input bit exp_ok,
                            input bit gaps, input bit exp_abort);
    logic [DW-1:0] beat, exp_d;
    bit            is_data;
    is_data = (f[FW-1 -: 2] == 2'b01);
    for (int b = 0; b < 4; b++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle_cycle();
      beat = f[FW-1-DW*b -: DW];
      drive_beat(beat, b == 0);
      exp_d = beat;
      if (b == 3) exp_d[11:0] = '0;
      if (b == 3 && exp_ok && is_data) tb_id = tb_id + 8'd1;
      checks++;
      if (out_valid !== 1'b1 || out_sof !== (b == 0) || out_eof !== (b == 3)) begin
        errors++;
        $display("FAIL framing_beat%0d: got valid=%b sof=%b eof=%b, expected 1 %b %b",
                 b, out_valid, out_sof, out_eof, b == 0, b == 3);
      end
      checks++;
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL data_beat%0d: got %h expected %h", b, data_out, exp_d);
      end
      checks++;
      if (frame_ok !== (b == 3 && exp_ok) || frame_err !== (b == 3 && !exp_ok)) begin
        errors++;
        $display("FAIL verdict_beat%0d: got ok=%b err=%b, expected ok=%b err=%b",
                 b, frame_ok, frame_err, b == 3 && exp_ok, b == 3 && !exp_ok);
      end
      checks++;
      if (frame_abort !== (b == 0 && exp_abort)) begin
        errors++;
        $display("FAIL abort_beat%0d: got %b expected %b", b, frame_abort, b == 0 && exp_abort);
      end
      if (b == 3) begin
        checks++;
        if (frame_is_data !== is_data) begin
          errors++;
          $display("FAIL is_data: got %b expected %b", frame_is_data, is_data);
        end
      end
      checks++;
      if (exp_frame_id !== tb_id) begin
        errors++;
        $display("FAIL exp_id_beat%0d: got %0d expected %0d", b, exp_frame_id, tb_id);
      end
      if (frame_ok === 1'b1) ok_seen++;
    end
  endtask

  task automatic check_id(input logic [7:0] want, input string name);
    checks++;
    if (exp_frame_id !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, exp_frame_id, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 || data_out !== '0 ||
        frame_ok !== 1'b0 || frame_err !== 1'b0 || frame_abort !== 1'b0 ||
        frame_is_data !== 1'b0 || exp_frame_id !== 8'd0) begin
      errors++;
      $display("FAIL %s: got valid=%b sof=%b eof=%b data=%h ok=%b err=%b abort=%b data=%b id=%0d, expected all 0",
               name, out_valid, out_sof, out_eof, data_out, frame_ok, frame_err,
               frame_abort, frame_is_data, exp_frame_id);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    tb_id = 8'd0;
  endtask

  task automatic test_idle_drop();
    logic [FW-1:0] f;
    drive_beat(64'h0123_4567_89AB_CDEF, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop: got out_valid=%b expected 0", out_valid);
    end
    make_frame(8'd0, 2'b01, f);
    send_frame(f, 1'b1, 1'b0, 1'b0);
    check_id(8'd1, "idle_drop_id");
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f;
    do_reset();
    ok_seen = 0;
    for (int i = 0; i < 300; i++) begin
      make_frame(8'(i), 2'b01, f);
      send_frame(f, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (ok_seen != 300) begin
      errors++;
      $display("FAIL b2b_ok_count: got %0d expected 300", ok_seen);
    end
    check_id(8'd44, "b2b_final_id");
  endtask

  task automatic test_bit_flip();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      make_frame(8'(i), 2'b01, f);
      send_frame(f, 1'b1, 1'b0, 1'b0);
    end
    make_frame(8'd5, 2'b01, f);
    f[100] = ~f[100];
    send_frame(f, 1'b0, 1'b0, 1'b0);
    check_id(8'd5, "flip_hold_id");
    make_frame(8'd6, 2'b01, f);
    send_frame(f, 1'b0, 1'b0, 1'b0);
    check_id(8'd5, "flip_next_err_id");
    make_frame(8'd5, 2'b01, f);
    send_frame(f, 1'b1, 1'b0, 1'b0);
    check_id(8'd6, "retransmit_id");
  endtask

  task automatic test_control();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      make_frame(8'(i), 2'b01, f);
      send_frame(f, 1'b1, 1'b0, 1'b0);
    end
    make_frame(8'd4, 2'b10, f);
    send_frame(f, 1'b1, 1'b0, 1'b0);
    check_id(8'd4, "control_id");
    make_frame(8'd4, 2'b01, f);
    send_frame(f, 1'b1, 1'b0, 1'b0);
    check_id(8'd5, "after_control_id");
  endtask

  task automatic test_abort();
    logic [FW-1:0] f_old, f_new;
    make_frame(8'd5, 2'b01, f_old);
    send_partial(f_old, 2);
    make_frame(8'd5, 2'b01, f_new);
    send_frame(f_new, 1'b1, 1'b0, 1'b1);
    check_id(8'd6, "abort_id");
  endtask

  task automatic test_gaps();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      make_frame(8'(i), 2'b01, f);
      send_frame(f, 1'b1, 1'b1, 1'b0);
    end
    make_frame(8'd10, 2'b01, f);
    f[200] = ~f[200];
    send_frame(f, 1'b0, 1'b1, 1'b0);
    make_frame(8'd10, 2'b01, f);
    send_frame(f, 1'b1, 1'b1, 1'b0);
    check_id(8'd11, "gaps_id");
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f;
    make_frame(8'd11, 2'b01, f);
    send_partial(f, 2);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    tb_id = 8'd0;
    make_frame(8'd0, 2'b01, f);
    send_frame(f, 1'b1, 1'b0, 1'b0);
    check_id(8'd1, "reset_mid_id");
  endtask

`ifdef VCODE_CHECK_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [FW-1:0] f;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      make_frame(8'd0, 2'b01, f);
      f[150 + i] = ~f[150 + i];
      send_frame(f, 1'b0, 1'b0, 1'b0);
    end
    make_frame(8'd0, 2'b01, f);
    send_partial(f, 2);
    make_frame(8'd0, 2'b01, f);
    send_frame(f, 1'b1, 1'b0, 1'b1);
    idle_cycle();
    checks++;
    if (err_cnt !== 16'd4) begin
      errors++;
      $display("FAIL err_cnt_count: got %0d expected 4", err_cnt);
    end
    @(negedge clk);
    err_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    err_cnt_clr = 1'b0;
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL err_cnt_clear: got %0d expected 0", err_cnt);
    end
  endtask
`endif

  // Test sequence and summary.
  initial begin
    test_reset();
    test_idle_drop();
    test_back_to_back();
    test_bit_flip();
    test_control();
    test_abort();
    test_gaps();
    test_reset_mid();
`ifdef VCODE_CHECK_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vcode_check.md
# vcode_check

Receive-side verification-code checker; mirror of the TX verification-code generator. Accepts a frame stream beat by beat, recomputes the frame CRC, and removes the expected frame ID from the received CRC field. It delivers each frame downstream, with the CRC field zeroed, together with a per-frame good/bad verdict. It sits after the RX gearbox/descrambler and before the frame decoder and retransmit logic.

## Interface
- FRAME_WIDTH, 256, frame size in bits; must be a power-of-two multiple of DWIDTH.
- DWIDTH, 64, beat width in bits.
- CRC_WIDTH, 12, CRC field width; the field occupies the low bits of a frame's last beat.
- CRC_POLY, 12'h02f, CRC polynomial in normal representation, with the implicit top bit omitted.
- FRAME_ID_WIDTH, 8, width of the frame sequence ID; must be ≤ CRC_WIDTH.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_sof  in  1  first beat of a frame; qualified by in_valid.
- data_in  in  DWIDTH  input beat.
- out_valid  out  1  output beat valid.
- out_sof  out  1  first beat of the output frame.
- out_eof  out  1  last beat of the output frame.
- data_out  out  DWIDTH  output beat; on the last beat, bits [CRC_WIDTH-1:0] are forced to 0.
- frame_ok  out  1  one-cycle pulse with out_eof: CRC and frame ID match.
- frame_err  out  1  one-cycle pulse with out_eof: mismatch.
- frame_abort  out  1  one-cycle pulse: a frame was truncated by an early sof.
- frame_is_data  out  1  valid with out_eof; the frame header was 2'b01.
- exp_frame_id  out  FRAME_ID_WIDTH  current expected frame ID.

## Operation
- BEATS = FRAME_WIDTH/DWIDTH. A beat counter `cnt` advances only on accepted beats (in_valid=1).
- States:
  - IDLE (cnt=0): a beat with in_sof=1 starts a frame. A beat without sof is dropped, and out_valid stays 0.
  - BUSY (cnt=1..BEATS-1): accepts beats. The beat at cnt=BEATS-1 is the last beat; the block then returns to IDLE.
  - BEATS=1: every sof beat is both first and last.
- Header: on the sof beat, latch is_data = (data_in[DWIDTH-1-:2] == 2'b01).
- CRC: serial-equivalent update, MSB of the beat first, starting from 0 at each sof.
  - On the last beat, data_in[CRC_WIDTH-1:0] is replaced by zeros before being fed to the CRC.
  - Running remainder is held across beats.
- Check on the last beat: rx_code = data_in[CRC_WIDTH-1:0] ^ zero-extended exp_frame_id; match = (rx_code == computed CRC).
- Frame ID:
  - On match with is_data=1, exp_frame_id increments, wrapping at 2^FRAME_ID_WIDTH.
  - Control frames and mismatched frames leave it unchanged.
  - A lost or duplicated frame therefore surfaces as frame_err.
- Early sof in BUSY:
  - frame_abort pulses, and no verdict is issued for the old frame.
  - exp_frame_id is unchanged.
  - The sof beat starts the new frame, with CRC reset.
- in_valid=0 mid-frame: the block holds all state; out_valid=0 that cycle.

## Timing
- Latency: exactly 1 cycle, input beat to output beat. Verdict pulses are aligned with out_eof of the same beat.
- frame_abort is asserted in the cycle in which the truncating sof beat appears at the output.
- exp_frame_id updates the cycle after the last beat is accepted, i.e. concurrently with out_eof.
- Reset values:
  - All outputs 0, including data_out; exp_frame_id=0.
  - cnt=0, CRC remainder 0.
- Reset mid-frame discards the partial frame; no verdict and no abort are issued.
- No backpressure: the downstream block must accept every out_valid beat.

## Configuration
- VCODE_CHECK_ERR_CNT_EN defined:
  - Adds input err_cnt_clr (1 bit) and output err_cnt (16 bits).
  - err_cnt increments on frame_err or frame_abort and saturates at 16'hFFFF.
  - err_cnt_clr has priority and zeros the counter on the next edge.
  - Reset value 0.
- Macro undefined: neither port exists and no counter logic is built.

## Test plan
- Back-to-back data frames from the TX generator model, IDs 0..299 (default params):
  - 300 frame_ok pulses, no frame_err.
  - exp_frame_id = 300 mod 256 = 44.
  - data_out matches the input with the CRC field zeroed.
- Single-bit flip in beat 2 of frame 5:
  - frame_err for frame 5.
  - exp_frame_id holds at 5; frame 6 (sent with ID 6) also gets frame_err.
  - Retransmitting frame 5 then gets frame_ok.
- Control frame (header 2'b10) between data frames 3 and 4:
  - frame_ok with frame_is_data=0; exp_frame_id stays 4.
- Sof at cnt=2, followed by a full valid frame:
  - frame_abort once, then frame_ok; exp_frame_id unchanged by the abort.
- Random in_valid gaps (50% duty):
  - Same verdicts as the gap-free run; out_valid mirrors in_valid delayed by one cycle.
- rst_n pulled low mid-frame: outputs 0 immediately; the next full frame with ID 0 gets frame_ok.
- With VCODE_CHECK_ERR_CNT_EN: 3 corrupted frames then one abort give err_cnt=4; err_cnt_clr returns it to 0.
